// File: rtl/seq_check_sched.sv
// rtl/seq_check_sched.sv - round-robin scheduler sharing one sequence checker among NREQ requesters
// Optional per-requester pass/fail statistics: define SEQ_SCHED_STATS_EN.
module seq_check_sched #(
  parameter int NREQ = 4,
  parameter int WIN  = 5,
  parameter int LAT  = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            chk_en,
  input  logic            chk_match,
  input  logic            chk_fail,
  output logic            done,
  output logic [IDW-1:0]  done_id,
  output logic            done_pass,
  output logic            done_err,
  output logic            done_tmo,
  input  logic [IDW-1:0]  stat_sel,
  output logic [7:0]      stat_pass,
  output logic [7:0]      stat_fail
);

  localparam int TW = $clog2(WIN + LAT + 1);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

  state_t          state, next_state;
  logic [IDW-1:0]  ptr, cur_id, pick, idx;
  logic            found;
  logic [TW-1:0]   timer;
  logic            seen_m, seen_f;
  logic [NREQ-1:0] gnt_d;
  logic            chk_en_d, done_d, busy_d;

  // Scan from the pointer upward, wrapping, and take the first pending requester.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ARM;
      ARM:     next_state = WAIT;
      WAIT:    if (timer == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    if (state == IDLE && found) gnt_d = NREQ'(1) << pick;
    chk_en_d = (state == ARM);
    done_d   = (state == DONE);
    busy_d   = (next_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      busy      <= 1'b0;
      chk_en    <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      done_pass <= 1'b0;
      done_err  <= 1'b0;
      done_tmo  <= 1'b0;
      ptr       <= '0;
      cur_id    <= '0;
      timer     <= '0;
      seen_m    <= 1'b0;
      seen_f    <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      busy      <= busy_d;
      chk_en    <= chk_en_d;
      done      <= done_d;
      done_pass <= 1'b0;
      done_err  <= 1'b0;
      done_tmo  <= 1'b0;
      case (state)
        IDLE: if (found) cur_id <= pick;
        ARM: begin
          timer  <= TW'(WIN + LAT - 1);
          seen_m <= 1'b0;
          seen_f <= 1'b0;
        end
        WAIT: begin
          seen_m <= seen_m | chk_match;
          seen_f <= seen_f | chk_fail;
          if (timer != '0) timer <= timer - 1'b1;
        end
        DONE: begin
          done_id   <= cur_id;
          done_pass <= seen_m & ~seen_f;
          done_err  <= seen_m & seen_f;
          done_tmo  <= ~seen_m & ~seen_f;
          // Move past the served requester so a still-high req waits its turn.
          ptr       <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_SCHED_STATS_EN
  logic [7:0] pass_cnt [NREQ];
  logic [7:0] fail_cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        pass_cnt[i] <= '0;
        fail_cnt[i] <= '0;
      end
    end else if (done) begin
      if (done_pass && pass_cnt[done_id] != 8'hff)
        pass_cnt[done_id] <= pass_cnt[done_id] + 8'd1;
      if ((done_err || done_tmo) && fail_cnt[done_id] != 8'hff)
        fail_cnt[done_id] <= fail_cnt[done_id] + 8'd1;
    end
  end

  assign stat_pass = pass_cnt[stat_sel];
  assign stat_fail = fail_cnt[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_pass = 8'h00;
  assign stat_fail = 8'h00;
`endif

endmodule
